// File: rtl/x4l_spi_pkg.sv
// Shared constants for the XERA4Lite SPI target: register map, status bit
// positions and FSM state encoding.
package x4l_spi_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int STAT_RX_FULL = 0;
  localparam int STAT_TX_FULL = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_BUSY    = 3;
  localparam int STAT_IE      = 4;

  localparam int CTL_CLR_OVR  = 0;
  localparam int CTL_IE       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spit_state_t;

endpackage

// File: rtl/x4l_spi_if.sv
// Z80 I/O strobes and SPI pins of the SPI target; the 8-bit data bus stays a
// plain inout on the top module.
interface x4l_spi_if;
  logic ADD;
  logic nRD;
  logic nWR;
  logic nCS;
  logic SPI_CLK;
  logic SPI_CS;
  logic SPI_MOSI;
  logic SPI_MISO;

  modport master (output ADD, nRD, nWR, nCS, SPI_CLK, SPI_CS, SPI_MOSI,
                  input  SPI_MISO);
  modport slave  (input  ADD, nRD, nWR, nCS, SPI_CLK, SPI_CS, SPI_MOSI,
                  output SPI_MISO);
endinterface

// File: rtl/x4l_sync_edge.sv
// STAGES-deep synchronizer with registered one-cycle rise/fall pulses.
// STAGES must be at least 2.
module x4l_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic nRST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p;
  logic              prev;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync_p <= {STAGES{RST_VAL}};
      prev   <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
      prev   <= sync_p[STAGES-1];
      rise   <= sync_p[STAGES-1] & ~prev;
      fall   <= ~sync_p[STAGES-1] & prev;
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/x4l_spi_target.sv
// SPI mode-0 target with a two-register Z80 I/O window (data, status/control).
// Define X4L_SPIT_INT_EN to add the IE bit and the registered nINT output.
module x4l_spi_target
  import x4l_spi_pkg::*;
#(
  parameter int SCK_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  x4l_spi_if.slave   bus,
  inout  wire  [7:0] DATA
`ifdef X4L_SPIT_INT_EN
  ,
  output logic       nINT
`endif
);

  spit_state_t state, state_nxt;

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SCK_SYNC_STAGES-1:0] mosi_p;
  logic [SCK_SYNC_STAGES:0]   fill_p;
  logic cs_armed, cs_start;

  logic [7:0] tx_hold, tx_src, shreg, rx_byte, stat, rd_mux;
  logic [2:0] bit_cnt;
  logic       tx_full, rx_full, overrun, miso;
  logic       nrd_prev, nwr_prev;
  logic       rd_stb, wr_stb, rd_data_stb, wr_data_stb, wr_stat_stb;
  logic       do_load, do_shift, do_present, do_done, do_idle;
  logic       ie;

  x4l_sync_edge #(.STAGES(SCK_SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .CLK(CLK), .nRST(nRST), .d(bus.SPI_CLK),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  x4l_sync_edge #(.STAGES(SCK_SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .CLK(CLK), .nRST(nRST), .d(bus.SPI_CS),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // A select that was already low when reset released must go high before a
  // new transfer may start, so arming waits until the synchronizer has refilled.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mosi_p   <= '0;
      fill_p   <= '0;
      cs_armed <= 1'b0;
    end else begin
      mosi_p   <= {mosi_p[SCK_SYNC_STAGES-2:0], bus.SPI_MOSI};
      fill_p   <= {fill_p[SCK_SYNC_STAGES-1:0], 1'b1};
      cs_armed <= cs_armed | (fill_p[SCK_SYNC_STAGES] & cs_q);
    end
  end

  assign cs_start = cs_fall & cs_armed;

  assign rd_stb      = nrd_prev & ~bus.nRD & ~bus.nCS;
  assign wr_stb      = nwr_prev & ~bus.nWR & ~bus.nCS;
  assign rd_data_stb = rd_stb & (bus.ADD == REG_DATA);
  assign wr_data_stb = wr_stb & (bus.ADD == REG_DATA);
  assign wr_stat_stb = wr_stb & (bus.ADD == REG_STAT);

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (sck_rise && bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = cs_q ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

  always_comb begin
    do_idle    = (state == IDLE);
    do_load    = (state == LOAD);
    do_shift   = (state == SHIFT) & sck_rise;
    do_present = (state == SHIFT) & sck_fall;
    do_done    = (state == DONE);
  end

  assign tx_src = tx_full ? tx_hold : 8'hFF;

  // Where a set and a clear of the same flag coincide, the set wins.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      nrd_prev <= 1'b1;
      nwr_prev <= 1'b1;
      tx_hold  <= '0;
      tx_full  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      miso     <= 1'b1;
      rx_byte  <= '0;
      rx_full  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      nrd_prev <= bus.nRD;
      nwr_prev <= bus.nWR;
      if (rd_data_stb) rx_full <= 1'b0;
      if (wr_stat_stb && DATA[CTL_CLR_OVR]) overrun <= 1'b0;
      if (do_load) begin
        shreg   <= tx_src;
        miso    <= tx_src[7];
        bit_cnt <= '0;
        tx_full <= 1'b0;
      end
      if (wr_data_stb) begin
        tx_hold <= DATA;
        tx_full <= 1'b1;
      end
      if (do_idle) miso <= 1'b1;
      if (do_shift) begin
        shreg   <= {shreg[6:0], mosi_p[SCK_SYNC_STAGES-1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (do_present) miso <= shreg[7];
      if (do_done) begin
        if (!rx_full || rd_data_stb) begin
          rx_byte <= shreg;
          rx_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef X4L_SPIT_INT_EN
  logic nint_r;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ie     <= 1'b0;
      nint_r <= 1'b1;
    end else begin
      if (wr_stat_stb) ie <= DATA[CTL_IE];
      nint_r <= ~(ie & (rx_full | overrun));
    end
  end

  assign nINT = nint_r;
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    stat               = '0;
    stat[STAT_RX_FULL] = rx_full;
    stat[STAT_TX_FULL] = tx_full;
    stat[STAT_OVERRUN] = overrun;
    stat[STAT_BUSY]    = ~cs_q;
    stat[STAT_IE]      = ie;
  end

  assign rd_mux       = (bus.ADD == REG_STAT) ? stat : rx_byte;
  assign DATA         = (!bus.nCS && !bus.nRD) ? rd_mux : 8'hzz;
  assign bus.SPI_MISO = miso;

endmodule

// File: tb/tb_x4l_spi_target.sv
// Randomized bench for x4l_spi_target against a byte-level reference model.
`timescale 1ns/1ps
module tb_x4l_spi_target;
  import x4l_spi_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  wire  [7:0] DATA;
  logic [7:0] drv_data = 8'h00;
  logic       drv_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0] m_tx_hold, m_rx;
  logic       m_tx_full, m_rx_full, m_ovr, m_ie;

  assign DATA = drv_en ? drv_data : 8'hzz;

  x4l_spi_if bus ();

`ifdef X4L_SPIT_INT_EN
  logic nINT;
  x4l_spi_target #(.SCK_SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .DATA(DATA), .nINT(nINT));
`else
  x4l_spi_target #(.SCK_SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .DATA(DATA));
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_tx_hold = 8'h00; m_rx = 8'h00;
    m_tx_full = 1'b0;  m_rx_full = 1'b0; m_ovr = 1'b0; m_ie = 1'b0;
  endfunction

  function automatic logic [7:0] model_load();
    logic [7:0] v;
    v = m_tx_full ? m_tx_hold : 8'hFF;
    m_tx_full = 1'b0;
    return v;
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (!m_rx_full) begin
      m_rx = b;
      m_rx_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  function automatic logic [7:0] exp_stat();
    return {3'b000, m_ie, ~bus.SPI_CS, m_ovr, m_tx_full, m_rx_full};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(posedge CLK); #1;
    bus.nCS = 1'b0; bus.ADD = a; bus.nRD = 1'b0;
    @(negedge CLK);
    d = DATA;
    @(posedge CLK); #1;
    bus.nRD = 1'b1; bus.nCS = 1'b1;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(posedge CLK); #1;
    bus.nCS = 1'b0; bus.ADD = a; bus.nWR = 1'b0; drv_data = d; drv_en = 1'b1;
    @(posedge CLK); #1;
    bus.nWR = 1'b1; bus.nCS = 1'b1; drv_en = 1'b0;
  endtask

  task automatic z80_read_rx(input string tag);
    logic [7:0] d;
    bus_read(REG_DATA, d);
    chk(tag, d, m_rx);
    m_rx_full = 1'b0;
  endtask

  task automatic z80_write_tx(input logic [7:0] v);
    bus_write(REG_DATA, v);
    m_tx_hold = v;
    m_tx_full = 1'b1;
  endtask

  task automatic z80_write_stat(input logic [7:0] v);
    bus_write(REG_STAT, v);
    if (v[0]) m_ovr = 1'b0;
`ifdef X4L_SPIT_INT_EN
    m_ie = v[4];
`endif
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] d;
    bus_read(REG_STAT, d);
    chk(tag, d, exp_stat());
  endtask

  // Shift nbits MSB-first in mode 0; MISO is sampled just before each rising edge.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = mo[7-i];
      wait_clks(HALF);
      mi[7-i] = bus.SPI_MISO;
      bus.SPI_CLK = 1'b1;
      wait_clks(HALF);
      bus.SPI_CLK = 1'b0;
    end
  endtask

  task automatic session(input logic [7:0] b0, input logic [7:0] b1,
                         input int nbytes, input int last_bits);
    logic [7:0] exp_tx, got, mo, mask;
    int nb;
    bus.SPI_CS = 1'b0;
    exp_tx = model_load();
    wait_clks(HALF);
    for (int b = 0; b < nbytes; b++) begin
      mo = (b == 0) ? b0 : b1;
      nb = (b == nbytes - 1) ? last_bits : 8;
      spi_xfer(mo, nb, got);
      mask = 8'hFF << (8 - nb);
      chk("miso_bits", got & mask, exp_tx & mask);
      if (nb == 8) begin
        model_rx(mo);
        exp_tx = model_load();
      end
    end
    wait_clks(HALF);
    bus.SPI_CS = 1'b1;
    wait_clks(HALF);
    chk("miso_idle", {7'd0, bus.SPI_MISO}, 8'h01);
`ifdef X4L_SPIT_INT_EN
    chk("nint", {7'd0, nINT}, {7'd0, ~(m_ie & (m_rx_full | m_ovr))});
`endif
  endtask

  // Last rising edge is timed so the completed byte meets a Z80 data read.
  task automatic session_coincident(input logic [7:0] b);
    logic [7:0] exp_tx, got, rd;
    bus.SPI_CS = 1'b0;
    exp_tx = model_load();
    wait_clks(HALF);
    spi_xfer(b, 7, got);
    bus.SPI_MOSI = b[0];
    wait_clks(HALF);
    got[0] = bus.SPI_MISO;
    bus.SPI_CLK = 1'b1;
    repeat (SYNC + 1) @(posedge CLK);
    bus_read(REG_DATA, rd);
    chk("rx_coincident_old", rd, m_rx);
    m_rx = b;
    m_rx_full = 1'b1;
    wait_clks(HALF);
    bus.SPI_CLK = 1'b0;
    chk("miso_coincident", got, exp_tx);
    exp_tx = model_load();
    wait_clks(HALF);
    bus.SPI_CS = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, got;
    int nbytes, lbits;
    bus.ADD = 1'b0; bus.nRD = 1'b1; bus.nWR = 1'b1; bus.nCS = 1'b1;
    bus.SPI_CLK = 1'b0; bus.SPI_CS = 1'b1; bus.SPI_MOSI = 1'b0;
    model_reset();
    wait_clks(4);
    nRST = 1'b1;
    wait_clks(SYNC + 3);

    chk("rst_miso", {7'd0, bus.SPI_MISO}, 8'h01);
`ifdef X4L_SPIT_INT_EN
    chk("rst_nint", {7'd0, nINT}, 8'h01);
`endif
    chk_status("rst_stat");
    z80_read_rx("rst_rx");

    z80_write_tx(8'hA5);
    chk_status("tx_full_set");
    session(8'h3C, 8'h00, 1, 8);
    chk_status("after_3c");
    z80_read_rx("rx_3c");

    session(8'h11, 8'h22, 2, 8);
    chk_status("overrun_set");
    z80_read_rx("rx_11");
    z80_write_stat(8'h01);
    chk_status("overrun_clr");

    session(8'h5A, 8'h00, 1, 8);
    session_coincident(8'hC3);
    chk_status("coincident_stat");
    z80_read_rx("rx_c3");

    session(8'hF0, 8'h00, 1, 4);
    chk_status("abort_stat");
    session(8'h81, 8'h00, 1, 8);
    z80_read_rx("rx_81");

    z80_write_stat(8'h10);
    chk_status("ie_stat");
`ifdef X4L_SPIT_INT_EN
    session(8'h42, 8'h00, 1, 8);
    bus_read(REG_DATA, d);
    chk("rx_42", d, m_rx);
    m_rx_full = 1'b0;
    chk("nint_at_read", {7'd0, nINT}, 8'h00);
    wait_clks(1);
    chk("nint_released", {7'd0, nINT}, 8'h01);
`endif
    z80_write_stat(8'h00);

    z80_write_tx(8'h99);
    bus.SPI_CS = 1'b0;
    void'(model_load());
    wait_clks(HALF);
    spi_xfer(8'hF0, 4, got);
    nRST = 1'b0;
    wait_clks(2);
    nRST = 1'b1;
    model_reset();
    wait_clks(SYNC + 3);
    chk("midrst_miso", {7'd0, bus.SPI_MISO}, 8'h01);
    chk_status("midrst_stat");
    z80_read_rx("midrst_rx");
    spi_xfer(8'h0F, 4, got);
    chk("midrst_no_resume", got & 8'hF0, 8'hF0);
    chk_status("midrst_no_rx");
    bus.SPI_CS = 1'b1;
    wait_clks(HALF);
    session(8'h66, 8'h00, 1, 8);
    z80_read_rx("rx_after_rst");

    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(1) == 1) z80_write_tx(8'($urandom_range(255)));
      nbytes = $urandom_range(2, 1);
      lbits  = ($urandom_range(3) == 0) ? $urandom_range(7, 1) : 8;
      session(8'($urandom_range(255)), 8'($urandom_range(255)), nbytes, lbits);
      chk_status("rand_stat");
      if ($urandom_range(1) == 1) z80_read_rx("rand_rx");
      if ($urandom_range(3) == 0) z80_write_stat(8'($urandom_range(255)));
      chk_status("rand_stat2");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
